regfile_sequencer: RTL

Micro-sequencer that drives the control side of the 32x16 register file: it accepts one register-level operation at a time (up to two source reads, optional writeback), enables the tri-state read ports, and hands operands to the execute stage. When execution completes it generates the edge-sensitive write strobe. It sits between instruction decode (request side) and the register file and ALU (datapath side), and guarantees address and strobe ordering so that writes are glitch-free.

---
 rtl/regfile_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_sequencer.sv
// Register-file control sequencer: read enables, ex_start, write strobe.
// Optional build macro REGSEQ_ZERO_SKIP_EN: writes to r0 skip the WB states.
module regfile_sequencer #(
    parameter int EXEC_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [4:0]       req_rd,
    input  logic             req_use_a,
    input  logic             req_use_b,
    input  logic             req_wb,
    output logic [4:0]       regAddrA,
    output logic [4:0]       regAddrB,
    output logic [4:0]       regAddrD,
    output logic             regReA,
    output logic             regReB,
    output logic             regWeD,
    output logic             ex_start,
    input  logic             ex_done,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB_SETUP,
        S_WB_STROBE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(EXEC_TIMEOUT - 1);

    state_t     r_state;
    logic       r_wb;
    logic [7:0] r_tcnt;
    logic       w_wb_eff;

`ifdef REGSEQ_ZERO_SKIP_EN
    assign w_wb_eff = req_wb & (req_rd != 5'd0);
`else
    assign w_wb_eff = req_wb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wb        <= 1'b0;
            r_tcnt      <= 8'd0;
            req_ready   <= 1'b1;
            regAddrA    <= 5'd0;
            regAddrB    <= 5'd0;
            regAddrD    <= 5'd0;
            regReA      <= 1'b0;
            regReB      <= 1'b0;
            regWeD      <= 1'b0;
            ex_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            op_count    <= '0;
        end else begin
            ex_start <= 1'b0;
            regWeD   <= 1'b0;
            if (err_clr) timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        regAddrA  <= req_rs1;
                        regAddrB  <= req_rs2;
                        regAddrD  <= req_rd;
                        r_wb      <= w_wb_eff;
                        regReA    <= req_use_a;
                        regReB    <= req_use_b;
                        ex_start  <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    r_tcnt  <= 8'd0;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ex_done) begin
                        regReA <= 1'b0;
                        regReB <= 1'b0;
                        if (r_wb) begin
                            r_state <= S_WB_SETUP;
                        end else begin
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            op_count  <= op_count + 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end else if (r_tcnt == TMO_LAST) begin
                        // set beats a same-cycle err_clr
                        timeout_err <= 1'b1;
                        regReA      <= 1'b0;
                        regReB      <= 1'b0;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_WB_SETUP: begin
                    regWeD  <= 1'b1;
                    r_state <= S_WB_STROBE;
                end
                S_WB_STROBE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    op_count  <= op_count + 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
